// File: rtl/foc_enc_pipe.sv
// foc_enc_pipe: registered 4-to-5 forbidden-overlap (FOC) crosstalk-avoidance
// encoder with a 2-entry elastic output buffer and valid/ready handshakes.
// Each 4-bit input group is encoded to a 5-bit FOC codeword. Encoded words
// are queued FIFO-style, and out_data always shows the head entry.
// Optional build macro FOC_SHIELD_EN inserts one grounded shield wire between
// adjacent groups, which keeps the FOC property across group boundaries.
module foc_enc_pipe #(
  parameter int NGRP = 4,
  parameter int CNTW = 16,
  localparam int IW = 4 * NGRP,
`ifdef FOC_SHIELD_EN
  localparam int STRIDE = 6,
`else
  localparam int STRIDE = 5,
`endif
  localparam int OW = STRIDE * NGRP - (STRIDE - 5)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_data,
  output logic [CNTW-1:0] word_cnt
);

  // FOC codebook: one 4-bit group maps to one 5-bit codeword.
  function automatic logic [4:0] foc_cw(input logic [3:0] nib);
    logic [4:0] cw;
    case (nib)
      4'h0: cw = 5'b00000;
      4'h1: cw = 5'b00100;
      4'h2: cw = 5'b00001;
      4'h3: cw = 5'b00101;
      4'h4: cw = 5'b00011;
      4'h5: cw = 5'b00111;
      4'h6: cw = 5'b10011;
      4'h7: cw = 5'b10111;
      4'h8: cw = 5'b10000;
      4'h9: cw = 5'b10100;
      4'hA: cw = 5'b10001;
      4'hB: cw = 5'b10101;
      4'hC: cw = 5'b11000;
      4'hD: cw = 5'b11100;
      4'hE: cw = 5'b11001;
      default: cw = 5'b11101;
    endcase
    return cw;
  endfunction

  logic [OW-1:0]   enc_word;
  logic [OW-1:0]   head_q, head_d;
  logic [OW-1:0]   tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            push, pop;

  // Encode every group of the incoming word; shield positions stay at 0.
  always_comb begin
    // NOTE: a default assignment at the top of every combinational block
    // means no path leaves a bit unassigned, so no latch is inferred.
    enc_word = '0;
    for (int g = 0; g < NGRP; g++) begin
      enc_word[STRIDE*g +: 5] = foc_cw(in_data[4*g +: 4]);
    end
  end

  // Ready comes only from the registered count, so nothing from out_ready
  // reaches it combinationally. It is forced low while reset is held.
  assign in_ready  = rst_n & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign word_cnt  = cnt_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Buffer next state. head_q is the visible entry and tail_q the second
  // entry. head_q keeps its value when the buffer empties, so the bus
  // stays quiet while idle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) cnt_d = cnt_q + CNTW'(1);
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = enc_word;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = enc_word;
          end else if (push) begin
            tail_d  = enc_word;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          // A full buffer never accepts a push, so only a pop can happen.
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the two storage entries are reset along with the control state.
    // The reset value of out_data is observable, so it must be defined.
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples its pre-edge inputs.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_foc_enc_pipe.sv
// Self-checking bench for foc_enc_pipe (NGRP=4). A queue-based reference
// model holds the expected buffer contents. A second instance with a 3-bit
// counter exercises the word_cnt wrap.
module tb_foc_enc_pipe;
  localparam int NGRP = 4;
  localparam int IW   = 4 * NGRP;
`ifdef FOC_SHIELD_EN
  localparam int STRIDE = 6;
`else
  localparam int STRIDE = 5;
`endif
  localparam int OW = STRIDE * NGRP - (STRIDE - 5);

  // Codebook packed F..0, so codeword n sits at [5n+4:5n].
  localparam logic [79:0] CB = {5'b11101, 5'b11001, 5'b11100, 5'b11000,
                                5'b10101, 5'b10001, 5'b10100, 5'b10000,
                                5'b10111, 5'b10011, 5'b00111, 5'b00011,
                                5'b00101, 5'b00001, 5'b00100, 5'b00000};

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  in_data;
  logic           out_valid;
  logic           out_ready;
  logic [OW-1:0]  out_data;
  logic [15:0]    word_cnt;
  logic           s_in_ready, s_out_valid;
  logic [OW-1:0]  s_out_data;
  logic [2:0]     s_word_cnt;

  foc_enc_pipe #(.NGRP(NGRP), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .word_cnt(word_cnt));

  foc_enc_pipe #(.NGRP(NGRP), .CNTW(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .word_cnt(s_word_cnt));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [OW-1:0] q[$];
  logic [OW-1:0] held;
  int            exp_cnt;

  function automatic logic [OW-1:0] model_enc(input logic [IW-1:0] d);
    logic [OW-1:0] w;
    w = '0;
    for (int g = 0; g < NGRP; g++) w[g*STRIDE +: 5] = CB[d[4*g +: 4]*5 +: 5];
    return w;
  endfunction

  function automatic logic [OW-1:0] model_head();
    return (q.size() != 0) ? q[0] : held;
  endfunction

  task automatic model_reset();
    q.delete();
    held    = '0;
    exp_cnt = 0;
  endtask

  // One clock cycle: drive the inputs just after a negedge, compare the
  // outputs against the model, cross the posedge, then advance the model.
  task automatic cycle(input logic iv, input logic [IW-1:0] d,
                       input logic ordy, input logic fl);
    logic exp_push, exp_pop;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    n_checks += 5;
    if (in_ready !== (q.size() != 2)) begin
      n_fail++; $display("FAIL in_ready: got %b expected %b", in_ready, q.size() != 2);
    end
    if (out_valid !== (q.size() != 0)) begin
      n_fail++; $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
    end
    if (out_data !== model_head()) begin
      n_fail++; $display("FAIL out_data: got %h expected %h", out_data, model_head());
    end
    if (word_cnt !== exp_cnt[15:0]) begin
      n_fail++; $display("FAIL word_cnt: got %0d expected %0d", word_cnt, exp_cnt[15:0]);
    end
    if (s_word_cnt !== exp_cnt[2:0]) begin
      n_fail++; $display("FAIL word_cnt_wrap: got %0d expected %0d", s_word_cnt, exp_cnt[2:0]);
    end
    exp_push = iv && (q.size() != 2);
    exp_pop  = ordy && (q.size() != 0);
    @(posedge clk);
    held = model_head();
    if (!fl) begin
      if (exp_pop) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (exp_push) q.push_back(model_enc(d));
    end else begin
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = '1;
    model_reset();
    @(negedge clk); #1;
    n_checks += 4;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_word();
    logic [OW-1:0] want;
`ifdef FOC_SHIELD_EN
    want = 23'b11101_0_11001_0_11100_0_11000;
`else
    want = 20'b11101_11001_11100_11000;
`endif
    cycle(1'b1, 16'hFEDC, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1;
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", out_valid); end
    if (out_data !== want) begin n_fail++; $display("FAIL first_data: got %h expected %h", out_data, want); end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_codebook();
    for (int v = 0; v < 16; v++) cycle(1'b1, IW'(v), 1'b1, 1'b0);
    for (int v = 0; v < 16; v++) cycle(1'b1, IW'($urandom), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] third;
    third = IW'($urandom);
    cycle(1'b1, 16'h0001, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) cycle(1'b1, third, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, third, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int start;
    start = exp_cnt;
    for (int i = 0; i < 100; i++) cycle(1'b1, IW'($urandom), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (word_cnt !== 16'(start + 100)) begin
      n_fail++; $display("FAIL throughput_cnt: got %0d expected %0d", word_cnt, start + 100);
    end
  endtask

  task automatic test_flush();
    logic [OW-1:0] before_data;
    int            before_cnt;
    cycle(1'b1, IW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, IW'($urandom), 1'b0, 1'b0);
    before_data = model_head();
    before_cnt  = exp_cnt;
    cycle(1'b1, IW'($urandom), 1'b1, 1'b1);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
    if (out_data !== before_data) begin n_fail++; $display("FAIL flush_data: got %h expected %h", out_data, before_data); end
    if (word_cnt !== before_cnt[15:0]) begin n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", word_cnt, before_cnt); end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), IW'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
    cycle(1'b1, IW'($urandom), 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL arst_out_data: got %h expected 0", out_data); end
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_word_cnt: got %0d expected 0", word_cnt); end
    if (s_word_cnt !== 3'd0) begin n_fail++; $display("FAIL arst_word_cnt_wrap: got %0d expected 0", s_word_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, IW'($urandom), 1'b1, 1'b0);
  endtask

`ifdef FOC_SHIELD_EN
  task automatic test_shield();
    cycle(1'b1, 16'hFFFF, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (out_data !== 23'b11101_0_11101_0_11101_0_11101) begin
      n_fail++; $display("FAIL shield_data: got %b expected %b", out_data, 23'b11101_0_11101_0_11101_0_11101);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_first_word();
    test_codebook();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
`ifdef FOC_SHIELD_EN
    test_shield();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
